mixcol_sched: RTL
=================

# mixcol_sched

Round-robin scheduler that shares one `mixcolum` instance between two requesters, A and B. The instance is driven by the encrypt and decrypt round logic, or by the round logic and a key-expansion helper. `mixcolum` reads its `data_i` and `decrypt_i` inputs over four consecutive cycles, so this block does three things:

- captures the winning requester's 128-bit word and mode,
- holds both stable on the `mixcolum` inputs for the whole operation,
- returns the result to the owner with a `done` pulse, and flags an error if `mixcolum` never answers.

## Interface
Parameters:
- `TIMEOUT`, default 7: number of BUSY cycles without `mc_ready_i` before the operation is aborted (3-bit counter).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_a`, `req_b`  in  1  request level from A and B.
- `decrypt_a`, `decrypt_b`  in  1  mode: 1 = InvMixColumns, 0 = MixColumns.
- `data_a`, `data_b`  in  128  operand, sampled on the grant edge only.
- `ack_a`, `ack_b`  out  1  one-cycle pulse: request accepted, operand captured.
- `done_a`, `done_b`  out  1  one-cycle pulse: `result_o` is valid for that requester.
- `result_o`  out  128  last result; holds its value until the next completion.
- `err_o`  out  1  one-cycle pulse on timeout abort.
- `busy_o`  out  1  high in every state except IDLE.
- `mc_start_o`  out  1  drives `mixcolum` `start_i`.
- `mc_decrypt_o`  out  1  drives `mixcolum` `decrypt_i`.
- `mc_data_o`  out  128  drives `mixcolum` `data_i`.
- `mc_ready_i`  in  1  from `mixcolum` `ready_o`.
- `mc_data_i`  in  128  from `mixcolum` `data_o`.

## Operation
- All outputs are registered.
- Reset values:
  - every output is 0, including `result_o` and `mc_data_o`;
  - state = IDLE;
  - `last_grant` = B, so A wins the first contention;
  - counter = 0;
  - `owner` = A.
- States: IDLE, LAUNCH, BUSY.
- IDLE:
  - `req_a`/`req_b` are sampled only in this state.
  - If exactly one request is high, that requester wins.
  - If both are high, the requester that is not `last_grant` wins.
  - On the grant edge:
    - `owner` ← winner;
    - `mc_data_o` ← winner's data;
    - `mc_decrypt_o` ← winner's decrypt;
    - the matching ack is set;
    - `mc_start_o` ← 1;
    - next state = LAUNCH.
  - With no request, the block stays in IDLE.
- LAUNCH:
  - Lasts exactly one cycle, with ack and `mc_start_o` high.
  - On exit: ack ← 0, `mc_start_o` ← 0, counter ← 0, next state = BUSY.
- BUSY:
  - `mc_data_o` and `mc_decrypt_o` are held unchanged.
  - If `mc_ready_i` is high:
    - `result_o` ← `mc_data_i`;
    - `done_<owner>` ← 1;
    - `last_grant` ← `owner`;
    - next state = IDLE.
  - Otherwise, if counter == `TIMEOUT`-1:
    - `err_o` ← 1;
    - `last_grant` ← `owner`;
    - `result_o` is unchanged and no done pulse is generated;
    - next state = IDLE.
  - Otherwise the counter increments.
- `done_*` and `err_o` pulses are cleared one cycle after they are set.
- `mc_ready_i` is ignored in IDLE and LAUNCH.
- A `req` dropped before it is granted is simply withdrawn.
- A requester must deassert `req` the cycle after its ack; if `req` is still high when the block next returns to IDLE, that is a new request.
- `mc_data_o` keeps its last operand while in IDLE.

## Timing
- Let T be the IDLE cycle in which the request is sampled. The nominal sequence is:
  - T+1: LAUNCH, with `ack_x` = `mc_start_o` = 1 and `mc_data_o` valid;
  - T+2 … T+4: `mixcolum` runs its states 1-3, while this block is in BUSY;
  - T+5: `mc_ready_i` = 1, counter = 3;
  - T+6: `done_x` = 1, `result_o` valid, block back in IDLE.
- The earliest next ack is at T+7, so throughput is one operation per 6 cycles.
- Timeout: with no ready, `err_o` pulses at T+9 and the block is back in IDLE at T+9.
- Asynchronous reset mid-operation:
  - the block returns immediately to the reset values;
  - no done or err pulse is generated;
  - `mixcolum` shares the same reset and is reset too.

## Test plan
- Single A request: `req_a`=1, `decrypt_a`=0, `data_a`=db135345_f20a225c_01010101_c6c6c6c6 -> `ack_a` at T+1; `done_a` at T+6; `result_o`=8e4da1bc_9fdc589d_01010101_c6c6c6c6.
- Decrypt path: request B with `decrypt_b`=1 and operand 8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> `done_b` at T+6; `result_o`=db135345_f20a225c_01010101_c6c6c6c6; `mc_decrypt_o`=1 for T+1…T+5.
- Contention: `req_a`=`req_b`=1 held continuously after reset -> grant order A, B, A, B; acks 6 cycles apart; each done goes to the correct side.
- Operand hold: after `ack_a`, change `data_a` every cycle -> `mc_data_o` stays constant through T+5 and the result matches the captured operand.
- Timeout: stub `mixcolum` with `mc_ready_i` tied to 0 -> `err_o` pulses at T+9; no done pulse; `result_o` unchanged; the next request is accepted with the other requester preferred.
- Reset at T+3: all outputs are 0 the same cycle; after release, a fresh request to A (`last_grant` = B) completes normally.

Source files
------------

// File: rtl/mixcol_sched.sv
// mixcol_sched: round-robin arbiter that shares one mixcolum core between requesters A and B
// Ports:
//   clk, reset (async, active-low)
//   req_x/decrypt_x/data_x  requester side inputs (x = a, b); operand sampled on the grant edge only
//   ack_x, done_x           one-cycle pulses: request accepted / result_o valid for that requester
//   result_o                last mixcolum result, held until the next completion
//   err_o                   one-cycle pulse when mixcolum fails to answer within TIMEOUT cycles
//   busy_o                  high whenever the block is not idle
//   mc_*                    connection to the shared mixcolum instance
module mixcol_sched #(
    parameter int TIMEOUT = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_a,
    input  logic         req_b,
    input  logic         decrypt_a,
    input  logic         decrypt_b,
    input  logic [127:0] data_a,
    input  logic [127:0] data_b,
    output logic         ack_a,
    output logic         ack_b,
    output logic         done_a,
    output logic         done_b,
    output logic [127:0] result_o,
    output logic         err_o,
    output logic         busy_o,
    output logic         mc_start_o,
    output logic         mc_decrypt_o,
    output logic [127:0] mc_data_o,
    input  logic         mc_ready_i,
    input  logic [127:0] mc_data_i
);
    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY} state_t;

    localparam logic [2:0] CNT_LAST = 3'(TIMEOUT - 1);

    state_t       state_q, state_d;
    logic         owner_q, owner_d;
    logic         last_q, last_d;
    logic [2:0]   cnt_q, cnt_d;
    logic         ack_a_q, ack_a_d, ack_b_q, ack_b_d;
    logic         done_a_q, done_a_d, done_b_q, done_b_d;
    logic         err_q, err_d, busy_q, busy_d;
    logic         start_q, start_d, dec_q, dec_d;
    logic [127:0] mc_data_q, mc_data_d, result_q, result_d;
    logic         win_b;

    // owner/last_grant encoding: 0 = A, 1 = B; on contention the side not granted last wins
    assign win_b = req_b & (~req_a | ~last_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= 3'd0;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            done_a_q  <= 1'b0;
            done_b_q  <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
            dec_q     <= 1'b0;
            mc_data_q <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            ack_a_q   <= ack_a_d;
            ack_b_q   <= ack_b_d;
            done_a_q  <= done_a_d;
            done_b_q  <= done_b_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            start_q   <= start_d;
            dec_q     <= dec_d;
            mc_data_q <= mc_data_d;
            result_q  <= result_d;
        end
    end

    // pulses (ack, start, done, err) default low so each lasts exactly one cycle
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        ack_a_d   = 1'b0;
        ack_b_d   = 1'b0;
        done_a_d  = 1'b0;
        done_b_d  = 1'b0;
        err_d     = 1'b0;
        start_d   = 1'b0;
        dec_d     = dec_q;
        mc_data_d = mc_data_q;
        result_d  = result_q;
        case (state_q)
            IDLE: if (req_a | req_b) begin
                owner_d   = win_b;
                mc_data_d = win_b ? data_b : data_a;
                dec_d     = win_b ? decrypt_b : decrypt_a;
                ack_a_d   = ~win_b;
                ack_b_d   = win_b;
                start_d   = 1'b1;
                state_d   = LAUNCH;
            end
            LAUNCH: begin
                cnt_d   = 3'd0;
                state_d = BUSY;
            end
            BUSY: if (mc_ready_i) begin
                result_d = mc_data_i;
                done_a_d = ~owner_q;
                done_b_d = owner_q;
                last_d   = owner_q;
                state_d  = IDLE;
            end else if (cnt_q == CNT_LAST) begin
                err_d   = 1'b1;
                last_d  = owner_q;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
            default: state_d = IDLE;
        endcase
        // busy_o is registered, so it follows the state being entered
        busy_d = state_d != IDLE;
    end

    assign ack_a        = ack_a_q;
    assign ack_b        = ack_b_q;
    assign done_a       = done_a_q;
    assign done_b       = done_b_q;
    assign result_o     = result_q;
    assign err_o        = err_q;
    assign busy_o       = busy_q;
    assign mc_start_o   = start_q;
    assign mc_decrypt_o = dec_q;
    assign mc_data_o    = mc_data_q;
endmodule
